// File: rtl/conversor_bcd.sv
// Signed 8-bit to sign + three BCD digit codes for a display decoder.
// Sequential double-dabble: one load cycle, eight shift cycles, one result cycle.
module conversor_bcd (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Inicio,
    input  logic [7:0] Valor,
    output logic       Ocupado,
    output logic       Pronto,
    output logic [4:0] Sinal,
    output logic [4:0] Centena,
    output logic [4:0] Dezena,
    output logic [4:0] Unidade
);

    typedef enum logic [1:0] {
        OCIOSO,
        CARREGA,
        DESLOCA,
        FIM
    } state_t;

    state_t      state_q,   state_d;
    logic [2:0]  cnt_q,     cnt_d;
    logic [7:0]  valor_q,   valor_d;
    logic        neg_q,     neg_d;
    logic [7:0]  mag_q,     mag_d;
    logic [11:0] bcd_q,     bcd_d;
    logic [11:0] bcd_adj;
    logic [4:0]  sinal_q,   sinal_d;
    logic [4:0]  centena_q, centena_d;
    logic [4:0]  dezena_q,  dezena_d;
    logic [4:0]  unidade_q, unidade_d;
    logic        ocupado_q, ocupado_d;
    logic        pronto_q,  pronto_d;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        valor_d   = valor_q;
        neg_d     = neg_q;
        mag_d     = mag_q;
        bcd_d     = bcd_q;
        bcd_adj   = '0;
        sinal_d   = sinal_q;
        centena_d = centena_q;
        dezena_d  = dezena_q;
        unidade_d = unidade_q;

        case (state_q)
            OCIOSO: begin
                if (Inicio) begin
                    valor_d = Valor;
                    state_d = CARREGA;
                end
            end
            CARREGA: begin
                neg_d   = valor_q[7];
                mag_d   = valor_q[7] ? 8'(-valor_q) : valor_q;
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = DESLOCA;
            end
            DESLOCA: begin
                bcd_adj        = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
                {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                cnt_d          = cnt_q + 3'd1;
                // Outputs load from the final shift result so they change only on FIM entry.
                if (cnt_q == 3'd7) begin
                    state_d   = FIM;
                    sinal_d   = neg_q ? 5'b10000 : 5'b00000;
                    centena_d = {1'b0, bcd_d[11:8]};
                    dezena_d  = {1'b0, bcd_d[7:4]};
                    unidade_d = {1'b0, bcd_d[3:0]};
                end
            end
            FIM: begin
                if (Inicio) begin
                    valor_d = Valor;
                    state_d = CARREGA;
                end else begin
                    state_d = OCIOSO;
                end
            end
            default: state_d = OCIOSO;
        endcase

        ocupado_d = (state_d == CARREGA) || (state_d == DESLOCA);
        pronto_d  = (state_d == FIM);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= OCIOSO;
            cnt_q     <= '0;
            valor_q   <= '0;
            neg_q     <= 1'b0;
            mag_q     <= '0;
            bcd_q     <= '0;
            sinal_q   <= '0;
            centena_q <= '0;
            dezena_q  <= '0;
            unidade_q <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            valor_q   <= valor_d;
            neg_q     <= neg_d;
            mag_q     <= mag_d;
            bcd_q     <= bcd_d;
            sinal_q   <= sinal_d;
            centena_q <= centena_d;
            dezena_q  <= dezena_d;
            unidade_q <= unidade_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
        end
    end

    assign Ocupado = ocupado_q;
    assign Pronto  = pronto_q;
    assign Sinal   = sinal_q;
    assign Centena = centena_q;
    assign Dezena  = dezena_q;
    assign Unidade = unidade_q;

endmodule

// File: tb/tb_conversor_bcd.sv
// Scoreboard bench for conversor_bcd: expected codes are queued at start, compared at Pronto.
// Outputs are sampled on the falling edge; "cycle k" is the cycle ending at the k-th rising edge after Inicio is sampled.
module tb_conversor_bcd;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       Inicio;
    logic [7:0] Valor;
    logic       Ocupado;
    logic       Pronto;
    logic [4:0] Sinal;
    logic [4:0] Centena;
    logic [4:0] Dezena;
    logic [4:0] Unidade;
    logic [19:0] dut_codes;

    int errors = 0;
    int checks = 0;
    logic [19:0] sb[$];

    int pronto_pulses = 0;
    int overlap       = 0;
    int run_len       = 0;
    int max_run       = 0;

    conversor_bcd dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .Inicio  (Inicio),
        .Valor   (Valor),
        .Ocupado (Ocupado),
        .Pronto  (Pronto),
        .Sinal   (Sinal),
        .Centena (Centena),
        .Dezena  (Dezena),
        .Unidade (Unidade)
    );

    assign dut_codes = {Sinal, Centena, Dezena, Unidade};

    always #5 Clock = ~Clock;

    always @(negedge Clock) begin
        if (Pronto) begin
            if (run_len == 0) pronto_pulses++;
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
        if (Pronto && Ocupado) overlap++;
    end

    // Signed decimal reference: integer division, independent of the shift-add method.
    function automatic logic [19:0] ref_codes(input logic [7:0] v);
        int s;
        int a;
        s = int'($signed(v));
        a = (s < 0) ? -s : s;
        return {(s < 0) ? 5'b10000 : 5'b00000, 5'(a / 100), 5'((a / 10) % 10), 5'(a % 10)};
    endfunction

    // Drives Inicio for one cycle; returns at the falling edge of cycle 1.
    task automatic start_conv(input logic [7:0] v, input bit push, input logic [19:0] exp_codes);
        @(negedge Clock);
        Inicio = 1'b1;
        Valor  = v;
        if (push) sb.push_back(exp_codes);
        @(negedge Clock);
        Inicio = 1'b0;
        Valor  = 8'($urandom);
    endtask

    // Bounded wait for Pronto, starting at cycle k_start; reports the cycle and whether Ocupado held.
    task automatic wait_pronto(input int k_start, output int k, output bit busy_ok);
        k       = k_start;
        busy_ok = 1'b1;
        while (!Pronto && k < 40) begin
            if (!Ocupado) busy_ok = 1'b0;
            @(negedge Clock);
            k++;
        end
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        Inicio = 1'b0;
        Valor  = 8'h00;
        repeat (3) @(negedge Clock);
        checks++;
        if (Ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_ocupado: got %b expected 0", Ocupado);
        end
        checks++;
        if (Pronto !== 1'b0) begin
            errors++;
            $display("FAIL reset_pronto: got %b expected 0", Pronto);
        end
        checks++;
        if (dut_codes !== 20'h00000) begin
            errors++;
            $display("FAIL reset_codes: got %h expected 00000", dut_codes);
        end
        Resetn = 1'b1;
        @(negedge Clock);
    endtask

    task automatic test_vectors;
        logic [7:0]  vals [4];
        logic [19:0] exps [4];
        logic [19:0] exp_c;
        int k;
        bit busy_ok;
        vals = '{8'h00, 8'h7F, 8'h80, 8'hFF};
        exps = '{{5'b00000, 5'd0, 5'd0, 5'd0},
                 {5'b00000, 5'd1, 5'd2, 5'd7},
                 {5'b10000, 5'd1, 5'd2, 5'd8},
                 {5'b10000, 5'd0, 5'd0, 5'd1}};
        for (int i = 0; i < 4; i++) begin
            start_conv(vals[i], 1'b1, exps[i]);
            wait_pronto(1, k, busy_ok);
            exp_c = sb.pop_front();
            checks++;
            if (k !== 10) begin
                errors++;
                $display("FAIL vec_latency[%h]: got cycle %0d expected 10", vals[i], k);
            end
            checks++;
            if (busy_ok !== 1'b1) begin
                errors++;
                $display("FAIL vec_ocupado[%h]: got low during conversion expected high", vals[i]);
            end
            checks++;
            if (dut_codes !== exp_c) begin
                errors++;
                $display("FAIL vec_codes[%h]: got %h expected %h", vals[i], dut_codes, exp_c);
            end
            @(negedge Clock);
            checks++;
            if (Pronto !== 1'b0) begin
                errors++;
                $display("FAIL vec_pulse[%h]: got Pronto %b expected 0", vals[i], Pronto);
            end
            checks++;
            if (dut_codes !== exp_c) begin
                errors++;
                $display("FAIL vec_hold[%h]: got %h expected %h", vals[i], dut_codes, exp_c);
            end
        end
    endtask

    task automatic test_back_to_back;
        int k;
        bit busy_ok;
        int pulses0;
        logic [19:0] exp_c;
        pulses0 = pronto_pulses;
        start_conv(8'h2A, 1'b1, {5'b00000, 5'd0, 5'd4, 5'd2});
        repeat (3) @(negedge Clock);
        Inicio = 1'b1;
        Valor  = 8'h05;
        @(negedge Clock);
        Inicio = 1'b0;
        wait_pronto(5, k, busy_ok);
        exp_c = sb.pop_front();
        checks++;
        if (k !== 10) begin
            errors++;
            $display("FAIL b2b_first_latency: got cycle %0d expected 10", k);
        end
        checks++;
        if (dut_codes !== exp_c) begin
            errors++;
            $display("FAIL b2b_first_codes: got %h expected %h", dut_codes, exp_c);
        end
        Inicio = 1'b1;
        Valor  = 8'hF6;
        sb.push_back({5'b10000, 5'd0, 5'd1, 5'd0});
        @(negedge Clock);
        Inicio = 1'b0;
        Valor  = 8'h00;
        wait_pronto(1, k, busy_ok);
        exp_c = sb.pop_front();
        checks++;
        if (k !== 10) begin
            errors++;
            $display("FAIL b2b_second_latency: got cycle %0d expected 10", k);
        end
        checks++;
        if (busy_ok !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_ocupado: got low during conversion expected high");
        end
        checks++;
        if (dut_codes !== exp_c) begin
            errors++;
            $display("FAIL b2b_second_codes: got %h expected %h", dut_codes, exp_c);
        end
        repeat (15) @(negedge Clock);
        checks++;
        if (pronto_pulses - pulses0 !== 2) begin
            errors++;
            $display("FAIL b2b_pulse_count: got %0d expected 2", pronto_pulses - pulses0);
        end
    endtask

    task automatic test_reset_abort;
        int k;
        bit busy_ok;
        logic [19:0] exp_c;
        start_conv(8'h7F, 1'b1, {5'b00000, 5'd1, 5'd2, 5'd7});
        wait_pronto(1, k, busy_ok);
        exp_c = sb.pop_front();
        checks++;
        if (dut_codes !== exp_c) begin
            errors++;
            $display("FAIL abort_pre_codes: got %h expected %h", dut_codes, exp_c);
        end
        @(negedge Clock);
        start_conv(8'h63, 1'b0, 20'h0);
        repeat (4) @(negedge Clock);
        #1 Resetn = 1'b0;
        #1;
        checks++;
        if (Ocupado !== 1'b0) begin
            errors++;
            $display("FAIL abort_ocupado: got %b expected 0", Ocupado);
        end
        checks++;
        if (dut_codes !== 20'h00000) begin
            errors++;
            $display("FAIL abort_codes: got %h expected 00000", dut_codes);
        end
        checks++;
        if (Pronto !== 1'b0) begin
            errors++;
            $display("FAIL abort_pronto: got %b expected 0", Pronto);
        end
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        checks++;
        if ({Ocupado, Pronto, dut_codes} !== 22'h0) begin
            errors++;
            $display("FAIL abort_after_release: got %h expected 000000", {Ocupado, Pronto, dut_codes});
        end
        start_conv(8'h63, 1'b1, {5'b00000, 5'd0, 5'd9, 5'd9});
        wait_pronto(1, k, busy_ok);
        exp_c = sb.pop_front();
        checks++;
        if (k !== 10) begin
            errors++;
            $display("FAIL abort_restart_latency: got cycle %0d expected 10", k);
        end
        checks++;
        if (dut_codes !== exp_c) begin
            errors++;
            $display("FAIL abort_restart_codes: got %h expected %h", dut_codes, exp_c);
        end
    endtask

    task automatic test_sweep;
        int k;
        bit busy_ok;
        logic [19:0] exp_c;
        for (int i = 0; i < 256; i++) begin
            start_conv(8'(i), 1'b1, ref_codes(8'(i)));
            wait_pronto(1, k, busy_ok);
            exp_c = sb.pop_front();
            checks++;
            if (k !== 10 || dut_codes !== exp_c) begin
                errors++;
                $display("FAIL sweep[%0d]: got cycle %0d codes %h expected cycle 10 codes %h",
                         i, k, dut_codes, exp_c);
            end
        end
        @(negedge Clock);
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL sweep_overlap: got %0d overlapping cycles expected 0", overlap);
        end
        checks++;
        if (max_run !== 1) begin
            errors++;
            $display("FAIL sweep_pulse_width: got %0d cycles expected 1", max_run);
        end
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d entries expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
